// File: rtl/minimig_bankmap_pkg.sv
// Shared definitions for the Minimig registered bank mapper: FSM states,
// bank field offsets (relative to the top of the chip fold field) and chip size codes.
package minimig_bankmap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_APPLY = 2'd2
  } bankmap_state_e;

  // Offsets above the CHIP_BLOCKS-wide fold field in the bank vector
  localparam int unsigned BIT_SLOW    = 0;
  localparam int unsigned BIT_CHIP    = 1;
  localparam int unsigned BIT_KICKEXT = 2;
  localparam int unsigned BIT_KICK    = 3;

  localparam logic [1:0] CHIP_0M5 = 2'b00;
  localparam logic [1:0] CHIP_1M0 = 2'b01;
  localparam logic [1:0] CHIP_1M5 = 2'b10;
  localparam logic [1:0] CHIP_2M0 = 2'b11;

  // Number of active fold slots for a size code; OCS/non-ECS setups see at most 1MB of chip RAM
  function automatic logic [3:0] fold_count(input logic [1:0] size_code, input logic ecs_en,
                                            input int unsigned blocks);
    logic [3:0] n;
    n = 4'(size_code) + 4'd1;
    if (32'(n) > blocks) n = 4'(blocks);
    if (!ecs_en && n > 4'd2) n = 4'd2;
    return n;
  endfunction

endpackage

// File: rtl/minimig_bankmap_fold.sv
// Combinational chip-select fold: maps CHIP_BLOCKS select lines onto n fold slots,
// aliasing upper blocks only when n is a power of two.
module minimig_bankmap_fold #(
  parameter int unsigned CHIP_BLOCKS = 4
) (
  input  logic [CHIP_BLOCKS-1:0] chip_sel,
  input  logic [3:0]             n,
  output logic [CHIP_BLOCKS-1:0] fold
);

  int unsigned nn;
  int unsigned mask;
  logic        pow2;

  always_comb begin
    nn   = 32'(n);
    mask = nn - 1;
    pow2 = (nn != 0) && ((nn & mask) == 0);
    fold = '0;
    // Output-major form avoids variable bit indexing; slots >= n are never targeted
    for (int unsigned j = 0; j < CHIP_BLOCKS; j++) begin
      for (int unsigned i = 0; i < CHIP_BLOCKS; i++) begin
        if (i < nn) begin
          if (i == j) fold[j] = fold[j] | chip_sel[i];
        end else if (pow2 && ((i & mask) == j)) begin
          fold[j] = fold[j] | chip_sel[i];
        end
      end
    end
  end

endmodule

// File: rtl/minimig_bankmapper_seq.sv
// Registered chip/slow/ROM bank mapper with idle-deferred configuration changes.
// Optional sticky multi-region select check: define MINIMIG_BANKMAP_CHECK_EN.
module minimig_bankmapper_seq
  import minimig_bankmap_pkg::*;
#(
  parameter int unsigned CHIP_BLOCKS = 4,
  parameter int unsigned SLOW_BLOCKS = 3,
  parameter int unsigned DRAIN_CYC   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   as,
  input  logic                   bus_idle,
  input  logic [CHIP_BLOCKS-1:0] chip_sel,
  input  logic [SLOW_BLOCKS-1:0] slow_sel,
  input  logic                   kick,
  input  logic                   kickext,
  input  logic                   kick1mb,
  input  logic                   cart,
  input  logic                   ecs,
  input  logic [3:0]             memory_config,
  output logic [CHIP_BLOCKS+3:0] bank,
  output logic                   bank_valid,
  output logic [3:0]             cfg_active,
  output logic                   cfg_pending,
  output logic                   cfg_changed,
  output logic                   sel_err
);

  bankmap_state_e        state, state_next;
  logic [3:0]            cnt, cnt_next;
  logic                  ecs_act;
  logic                  req_differs;
  logic [3:0]            n;
  logic [CHIP_BLOCKS-1:0] fold;
  logic [CHIP_BLOCKS+3:0] bank_map;

  assign req_differs = {memory_config, ecs} != {cfg_active, ecs_act};
  assign n           = fold_count(cfg_active[1:0], ecs_act, CHIP_BLOCKS);
  assign cfg_pending = (state == ST_PEND);

  minimig_bankmap_fold #(.CHIP_BLOCKS(CHIP_BLOCKS)) u_fold (
    .chip_sel (chip_sel),
    .n        (n),
    .fold     (fold)
  );

  always_comb begin
    bank_map                          = '0;
    bank_map[CHIP_BLOCKS-1:0]         = fold;
    bank_map[CHIP_BLOCKS+BIT_SLOW]    = (|slow_sel) | kick1mb | cart;
    bank_map[CHIP_BLOCKS+BIT_CHIP]    = |chip_sel;
    bank_map[CHIP_BLOCKS+BIT_KICKEXT] = kickext;
    bank_map[CHIP_BLOCKS+BIT_KICK]    = kick;
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE: begin
        cnt_next = '0;
        if (req_differs) state_next = ST_PEND;
      end
      ST_PEND: begin
        // A reverted request wins over a completed drain
        if (!req_differs) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = bus_idle ? cnt + 4'd1 : '0;
          if (cnt_next == 4'(DRAIN_CYC)) state_next = ST_APPLY;
        end
      end
      ST_APPLY: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bank        <= '0;
      bank_valid  <= 1'b0;
      cfg_active  <= '0;
      ecs_act     <= 1'b0;
      cfg_changed <= 1'b0;
    end else begin
      cfg_changed <= (state == ST_APPLY);
      if (state == ST_APPLY) begin
        cfg_active <= memory_config;
        ecs_act    <= ecs;
      end
      if (state == ST_APPLY || !as) begin
        bank       <= '0;
        bank_valid <= 1'b0;
      end else begin
        bank       <= bank_map;
        bank_valid <= 1'b1;
      end
    end
  end

`ifdef MINIMIG_BANKMAP_CHECK_EN
  logic [4:0] regions;
  logic       multi_hit;

  assign regions   = {|chip_sel, |slow_sel, kick, kickext, cart};
  assign multi_hit = (regions & (regions - 5'd1)) != 5'd0;

  always_ff @(posedge clk) begin
    if (reset) sel_err <= 1'b0;
    else if (as && multi_hit) sel_err <= 1'b1;
  end
`else
  assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_minimig_bankmapper_seq.sv
// Directed self-checking bench for minimig_bankmapper_seq (CHIP_BLOCKS=4, SLOW_BLOCKS=3, DRAIN_CYC=2).
module tb_minimig_bankmapper_seq;

  logic       clk = 1'b0;
  logic       reset, as, bus_idle, kick, kickext, kick1mb, cart, ecs;
  logic [3:0] chip_sel;
  logic [2:0] slow_sel;
  logic [3:0] memory_config;
  logic [7:0] bank;
  logic       bank_valid, cfg_pending, cfg_changed, sel_err;
  logic [3:0] cfg_active;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef MINIMIG_BANKMAP_CHECK_EN
  localparam logic SEL_ERR_EXP = 1'b1;
`else
  localparam logic SEL_ERR_EXP = 1'b0;
`endif

  always #5 clk = ~clk;

  minimig_bankmapper_seq #(.CHIP_BLOCKS(4), .SLOW_BLOCKS(3), .DRAIN_CYC(2)) dut (
    .clk(clk), .reset(reset), .as(as), .bus_idle(bus_idle), .chip_sel(chip_sel),
    .slow_sel(slow_sel), .kick(kick), .kickext(kickext), .kick1mb(kick1mb), .cart(cart),
    .ecs(ecs), .memory_config(memory_config), .bank(bank), .bank_valid(bank_valid),
    .cfg_active(cfg_active), .cfg_pending(cfg_pending), .cfg_changed(cfg_changed),
    .sel_err(sel_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a new config with the bus idle and let it drain, apply and settle back to IDLE
  task automatic set_cfg(input logic [3:0] cfg, input logic e);
    memory_config = cfg;
    ecs           = e;
    bus_idle      = 1'b1;
    repeat (5) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++; if (bank !== 8'h00)      begin n_fail++; $display("FAIL reset_bank: got %h expected 00", bank); end
    n_checks++; if (bank_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bank_valid); end
    n_checks++; if (cfg_active !== 4'h0) begin n_fail++; $display("FAIL reset_cfg_active: got %h expected 0", cfg_active); end
    n_checks++; if (cfg_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %b expected 0", cfg_pending); end
    n_checks++; if (cfg_changed !== 1'b0) begin n_fail++; $display("FAIL reset_changed: got %b expected 0", cfg_changed); end
    n_checks++; if (sel_err !== 1'b0)    begin n_fail++; $display("FAIL reset_sel_err: got %b expected 0", sel_err); end
  endtask

  task automatic test_apply_after_reset();
    memory_config = 4'b0011;
    ecs           = 1'b1;
    bus_idle      = 1'b1;
    tick();
    n_checks++; if (cfg_pending !== 1'b0) begin n_fail++; $display("FAIL held_reset_pending: got %b expected 0", cfg_pending); end
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if (cfg_changed !== (c == 3)) begin
        n_fail++; $display("FAIL apply_pulse_c%0d: got %b expected %b", c, cfg_changed, (c == 3));
      end
      n_checks++;
      if (cfg_pending !== (c < 2)) begin
        n_fail++; $display("FAIL apply_pending_c%0d: got %b expected %b", c, cfg_pending, (c < 2));
      end
    end
    n_checks++; if (cfg_active !== 4'h3) begin n_fail++; $display("FAIL apply_cfg_active: got %h expected 3", cfg_active); end
    as = 1'b1; chip_sel = 4'b1000;
    tick();
    n_checks++; if (bank !== 8'h28)      begin n_fail++; $display("FAIL map_2m_blk3: got %h expected 28", bank); end
    n_checks++; if (bank_valid !== 1'b1) begin n_fail++; $display("FAIL map_2m_valid: got %b expected 1", bank_valid); end
    as = 1'b0; chip_sel = 4'b0000;
    tick();
    n_checks++; if (bank !== 8'h00)      begin n_fail++; $display("FAIL idle_bank: got %h expected 00", bank); end
    n_checks++; if (bank_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b expected 0", bank_valid); end
  endtask

  task automatic test_fold();
    logic [3:0] v_cfg  [7];
    logic [3:0] v_chip [7];
    logic [7:0] v_exp  [7];
    logic [4:0] f_in   [4];
    logic [7:0] f_exp  [4];
    v_cfg[0] = 4'b0001; v_chip[0] = 4'b0100; v_exp[0] = 8'h21;
    v_cfg[1] = 4'b0001; v_chip[1] = 4'b1000; v_exp[1] = 8'h22;
    v_cfg[2] = 4'b0001; v_chip[2] = 4'b0011; v_exp[2] = 8'h23;
    v_cfg[3] = 4'b0010; v_chip[3] = 4'b1000; v_exp[3] = 8'h20;
    v_cfg[4] = 4'b0010; v_chip[4] = 4'b0100; v_exp[4] = 8'h24;
    v_cfg[5] = 4'b0000; v_chip[5] = 4'b1010; v_exp[5] = 8'h21;
    v_cfg[6] = 4'b0011; v_chip[6] = 4'b1111; v_exp[6] = 8'h2F;
    for (int i = 0; i < 7; i++) begin
      set_cfg(v_cfg[i], 1'b1);
      as = 1'b1; chip_sel = v_chip[i];
      tick();
      n_checks++;
      if (bank !== v_exp[i]) begin
        n_fail++; $display("FAIL fold_v%0d: cfg %b chip %b got %h expected %h", i, v_cfg[i], v_chip[i], bank, v_exp[i]);
      end
      as = 1'b0; chip_sel = 4'b0000;
      tick();
    end
    // {kick, kickext, kick1mb, cart, slow_sel[2]}
    f_in[0] = 5'b10000; f_exp[0] = 8'h80;
    f_in[1] = 5'b01100; f_exp[1] = 8'h50;
    f_in[2] = 5'b00010; f_exp[2] = 8'h10;
    f_in[3] = 5'b00001; f_exp[3] = 8'h10;
    for (int i = 0; i < 4; i++) begin
      as = 1'b1;
      {kick, kickext, kick1mb, cart} = f_in[i][4:1];
      slow_sel = {f_in[i][0], 2'b00};
      tick();
      n_checks++;
      if (bank !== f_exp[i]) begin
        n_fail++; $display("FAIL fields_v%0d: got %h expected %h", i, bank, f_exp[i]);
      end
    end
    as = 1'b0; {kick, kickext, kick1mb, cart} = 4'b0000; slow_sel = 3'b000;
    tick();
  endtask

  task automatic test_ecs_cap();
    set_cfg(4'b0011, 1'b0);
    n_checks++; if (cfg_active !== 4'h3) begin n_fail++; $display("FAIL ocs_cfg_active: got %h expected 3", cfg_active); end
    as = 1'b1; chip_sel = 4'b0100;
    tick();
    n_checks++; if (bank !== 8'h21) begin n_fail++; $display("FAIL ocs_cap_blk2: got %h expected 21", bank); end
    chip_sel = 4'b1000;
    tick();
    n_checks++; if (bank !== 8'h22) begin n_fail++; $display("FAIL ocs_cap_blk3: got %h expected 22", bank); end
    as = 1'b0; chip_sel = 4'b0000;
    tick();
  endtask

  task automatic test_drain();
    logic idle_seq [4];
    idle_seq[0] = 1'b1; idle_seq[1] = 1'b0; idle_seq[2] = 1'b1; idle_seq[3] = 1'b1;
    memory_config = 4'b0001; ecs = 1'b0; bus_idle = 1'b1;
    tick();
    n_checks++; if (cfg_pending !== 1'b1) begin n_fail++; $display("FAIL drain_enter_pend: got %b expected 1", cfg_pending); end
    for (int k = 0; k < 4; k++) begin
      bus_idle = idle_seq[k];
      tick();
      n_checks++;
      if (cfg_changed !== 1'b0) begin n_fail++; $display("FAIL drain_early_k%0d: got %b expected 0", k, cfg_changed); end
      n_checks++;
      if (cfg_pending !== (k < 3)) begin
        n_fail++; $display("FAIL drain_pending_k%0d: got %b expected %b", k, cfg_pending, (k < 3));
      end
    end
    as = 1'b1; chip_sel = 4'b0001;
    tick();
    n_checks++; if (cfg_changed !== 1'b1) begin n_fail++; $display("FAIL drain_pulse: got %b expected 1", cfg_changed); end
    n_checks++; if (bank_valid !== 1'b0)  begin n_fail++; $display("FAIL apply_blank_valid: got %b expected 0", bank_valid); end
    n_checks++; if (bank !== 8'h00)       begin n_fail++; $display("FAIL apply_blank_bank: got %h expected 00", bank); end
    n_checks++; if (cfg_active !== 4'h1)  begin n_fail++; $display("FAIL drain_cfg_active: got %h expected 1", cfg_active); end
    as = 1'b0; chip_sel = 4'b0000;
    tick();
    n_checks++; if (cfg_changed !== 1'b0) begin n_fail++; $display("FAIL pulse_width: got %b expected 0", cfg_changed); end
    memory_config = 4'b0010;
    tick();
    n_checks++; if (cfg_pending !== 1'b1) begin n_fail++; $display("FAIL revert_pend: got %b expected 1", cfg_pending); end
    tick();
    memory_config = 4'b0001;
    tick();
    n_checks++; if (cfg_pending !== 1'b0) begin n_fail++; $display("FAIL revert_pending_clear: got %b expected 0", cfg_pending); end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (cfg_changed !== 1'b0) begin n_fail++; $display("FAIL revert_no_pulse_k%0d: got %b expected 0", k, cfg_changed); end
    end
    n_checks++; if (cfg_active !== 4'h1) begin n_fail++; $display("FAIL revert_cfg_active: got %h expected 1", cfg_active); end
  endtask

  task automatic test_sel_err();
    n_checks++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL sel_err_single_region: got %b expected 0", sel_err); end
    as = 1'b1; kick = 1'b1; cart = 1'b1;
    tick();
    n_checks++; if (sel_err !== SEL_ERR_EXP) begin n_fail++; $display("FAIL sel_err_set: got %b expected %b", sel_err, SEL_ERR_EXP); end
    as = 1'b0; kick = 1'b0; cart = 1'b0;
    tick();
    tick();
    n_checks++; if (sel_err !== SEL_ERR_EXP) begin n_fail++; $display("FAIL sel_err_sticky: got %b expected %b", sel_err, SEL_ERR_EXP); end
  endtask

  task automatic test_reset_mid_pend();
    memory_config = 4'b0011; ecs = 1'b1; bus_idle = 1'b1;
    as = 1'b1; chip_sel = 4'b0001;
    tick();
    n_checks++; if (cfg_pending !== 1'b1) begin n_fail++; $display("FAIL midpend_pending: got %b expected 1", cfg_pending); end
    n_checks++; if (bank !== 8'h21)       begin n_fail++; $display("FAIL midpend_bank: got %h expected 21", bank); end
    tick();
    reset = 1'b1;
    tick();
    n_checks++; if (bank !== 8'h00)       begin n_fail++; $display("FAIL rst2_bank: got %h expected 00", bank); end
    n_checks++; if (bank_valid !== 1'b0)  begin n_fail++; $display("FAIL rst2_valid: got %b expected 0", bank_valid); end
    n_checks++; if (cfg_active !== 4'h0)  begin n_fail++; $display("FAIL rst2_cfg_active: got %h expected 0", cfg_active); end
    n_checks++; if (cfg_pending !== 1'b0) begin n_fail++; $display("FAIL rst2_pending: got %b expected 0", cfg_pending); end
    n_checks++; if (cfg_changed !== 1'b0) begin n_fail++; $display("FAIL rst2_changed: got %b expected 0", cfg_changed); end
    n_checks++; if (sel_err !== 1'b0)     begin n_fail++; $display("FAIL rst2_sel_err: got %b expected 0", sel_err); end
    as = 1'b0; chip_sel = 4'b0000;
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if (cfg_changed !== (c == 3)) begin
        n_fail++; $display("FAIL rst2_full_drain_c%0d: got %b expected %b", c, cfg_changed, (c == 3));
      end
    end
  endtask

  initial begin
    reset = 1'b1; as = 1'b0; bus_idle = 1'b0; chip_sel = '0; slow_sel = '0;
    kick = 1'b0; kickext = 1'b0; kick1mb = 1'b0; cart = 1'b0; ecs = 1'b0; memory_config = '0;
    test_reset();
    test_apply_after_reset();
    test_fold();
    test_ecs_cap();
    test_drain();
    test_sel_err();
    test_reset_mid_pend();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
